// File: rtl/penta_root_sched.sv
// Job scheduler for the penta root ring engine: request arbitration,
// per-lane job tracking and a buffered valid/ready response channel.
module penta_root_sched #(
  parameter int N       = 1,
  parameter int NREQ    = 2,
  parameter int XW      = 1024,
  parameter int TW      = 8,
  parameter int LATENCY = 258,
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int OW     = $clog2(N + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*XW-1:0] req_x_i,
  input  logic [NREQ*TW-1:0] req_tag_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XW-1:0]     rsp_x_o,
  output logic [IW-1:0]     rsp_id_o,
  output logic [TW-1:0]     rsp_tag_o,
  output logic [N-1:0]      eng_start_o,
  output logic [N*XW-1:0]   eng_x_o,
  input  logic [N-1:0]      eng_done_i,
  input  logic [N*XW-1:0]   eng_x_i,
  output logic [OW-1:0]     inflight_o,
  output logic              err_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, HOLD} state_t;

  state_t        st     [N];
  state_t        st_nx  [N];
  logic [CW-1:0] cnt    [N];
  logic [CW-1:0] cnt_nx [N];
  logic [XW-1:0] data   [N];
  logic [IW-1:0] rid    [N];
  logic [TW-1:0] rtag   [N];
  logic [N-1:0]  ld_req;
  logic [N-1:0]  ld_res;

  logic [IW-1:0] req_ptr;
  logic [IW-1:0] gnt;
  logic          gnt_any;
  logic [PW-1:0] free_p;
  logic          free_any;
  logic          accept;

  logic [PW-1:0] rsp_ptr;
  logic [PW-1:0] sel;
  logic [PW-1:0] lock_sel;
  logic          lock;
  logic          hold_any;
  logic          rsp_hs;

  logic          err_ev;
  logic [OW-1:0] busy_nx;

  // request side: lowest idle lane, round-robin requester
  always_comb begin
    free_any = 1'b0;
    free_p   = '0;
    for (int p = N - 1; p >= 0; p--) begin
      if (st[p] == IDLE) begin
        free_any = 1'b1;
        free_p   = PW'(p);
      end
    end
    gnt_any = 1'b0;
    gnt     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_any &&
          req_valid_i[(int'(req_ptr) + i) % NREQ]) begin
        gnt_any = 1'b1;
        gnt     = IW'((int'(req_ptr) + i) % NREQ);
      end
    end
    accept      = gnt_any & free_any;
    req_ready_o = '0;
    if (accept && !rst_i) req_ready_o[gnt] = 1'b1;
  end

  // response side: a stalled selection stays locked until taken
  always_comb begin
    hold_any = 1'b0;
    sel      = '0;
    if (lock) begin
      hold_any = 1'b1;
      sel      = lock_sel;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!hold_any &&
            st[(int'(rsp_ptr) + i) % N] == HOLD) begin
          hold_any = 1'b1;
          sel      = PW'((int'(rsp_ptr) + i) % N);
        end
      end
    end
    rsp_hs      = hold_any & rsp_ready_i;
    rsp_valid_o = hold_any;
    rsp_x_o     = hold_any ? data[sel] : '0;
    rsp_id_o    = hold_any ? rid[sel]  : '0;
    rsp_tag_o   = hold_any ? rtag[sel] : '0;
  end

  always_comb begin
    err_ev  = 1'b0;
    busy_nx = '0;
    ld_req  = '0;
    ld_res  = '0;
    for (int p = 0; p < N; p++) begin
      st_nx[p]  = st[p];
      cnt_nx[p] = cnt[p];
      unique case (st[p])
        IDLE: begin
          if (eng_done_i[p]) err_ev = 1'b1;
          if (accept && free_p == PW'(p)) begin
            st_nx[p]  = ISSUE;
            ld_req[p] = 1'b1;
          end
        end
        ISSUE: begin
          if (eng_done_i[p]) err_ev = 1'b1;
          st_nx[p]  = RUN;
          cnt_nx[p] = CW'(LATENCY - 1);
        end
        RUN: begin
          if (cnt[p] == '0) begin
            if (eng_done_i[p]) begin
              st_nx[p]  = HOLD;
              ld_res[p] = 1'b1;
            end else begin
              st_nx[p] = IDLE;
              err_ev   = 1'b1;
            end
          end else begin
            cnt_nx[p] = cnt[p] - 1'b1;
            if (eng_done_i[p]) err_ev = 1'b1;
          end
        end
        HOLD: begin
          if (eng_done_i[p]) err_ev = 1'b1;
          if (rsp_hs && sel == PW'(p)) st_nx[p] = IDLE;
        end
      endcase
      busy_nx = busy_nx + OW'(st_nx[p] != IDLE);
    end
  end

  always_comb begin
    eng_start_o = '0;
    eng_x_o     = '0;
    for (int p = 0; p < N; p++) begin
      if (st[p] == ISSUE) begin
        eng_start_o[p]         = 1'b1;
        eng_x_o[p*XW +: XW]    = data[p];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < N; p++) begin
        st[p]   <= IDLE;
        cnt[p]  <= '0;
        data[p] <= '0;
        rid[p]  <= '0;
        rtag[p] <= '0;
      end
      req_ptr    <= '0;
      rsp_ptr    <= '0;
      lock       <= 1'b0;
      lock_sel   <= '0;
      err_o      <= 1'b0;
      inflight_o <= '0;
    end else begin
      for (int p = 0; p < N; p++) begin
        st[p]  <= st_nx[p];
        cnt[p] <= cnt_nx[p];
        if (ld_req[p]) begin
          data[p] <= req_x_i[int'(gnt)*XW +: XW];
          rid[p]  <= gnt;
          rtag[p] <= req_tag_i[int'(gnt)*TW +: TW];
        end else if (ld_res[p]) begin
          data[p] <= eng_x_i[p*XW +: XW];
        end
      end
      if (accept)
        req_ptr <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
      if (rsp_hs)
        rsp_ptr <= (int'(sel) == N - 1) ? '0 : sel + 1'b1;
      lock       <= hold_any & ~rsp_ready_i;
      lock_sel   <= sel;
      err_o      <= err_o | err_ev;
      inflight_o <= busy_nx;
    end
  end

endmodule

// File: tb/tb_penta_root_sched.sv
// Directed bench for penta_root_sched with a small
// fixed-latency engine model (N=2, NREQ=3).
module tb_penta_root_sched;

  localparam int N    = 2;
  localparam int NREQ = 3;
  localparam int XW   = 16;
  localparam int TW   = 8;
  localparam int L    = 258;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NREQ-1:0]   req_valid_i;
  logic [NREQ-1:0]   req_ready_o;
  logic [NREQ*XW-1:0] req_x_i;
  logic [NREQ*TW-1:0] req_tag_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [XW-1:0]     rsp_x_o;
  logic [1:0]        rsp_id_o;
  logic [TW-1:0]     rsp_tag_o;
  logic [N-1:0]      eng_start_o;
  logic [N*XW-1:0]   eng_x_o;
  logic [N-1:0]      eng_done_i;
  logic [N*XW-1:0]   eng_x_i;
  logic [1:0]        inflight_o;
  logic              err_o;

  always #5 clk_i = ~clk_i;

  penta_root_sched #(
    .N(N), .NREQ(NREQ), .XW(XW), .TW(TW), .LATENCY(L)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_x_i(req_x_i), .req_tag_i(req_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_x_o(rsp_x_o), .rsp_id_o(rsp_id_o),
    .rsp_tag_o(rsp_tag_o),
    .eng_start_o(eng_start_o), .eng_x_o(eng_x_o),
    .eng_done_i(eng_done_i), .eng_x_i(eng_x_i),
    .inflight_o(inflight_o), .err_o(err_o)
  );

  int cyc;
  always @(posedge clk_i or posedge rst_i)
    if (rst_i) cyc <= 0;
    else       cyc <= cyc + 1;

  // engine model: done LATENCY cycles after the start cycle
  int          due   [N];
  logic [XW-1:0] rx  [N];
  bit          early [N];
  bit          miss  [N];
  bit          use_fix;
  logic [XW-1:0] fixres;

  always @(negedge clk_i) begin
    for (int p = 0; p < N; p++) begin
      if (rst_i) due[p] = -1;
      else if (eng_start_o[p]) begin
        due[p] = cyc + L;
        rx[p]  = use_fix ? fixres :
                 (eng_x_o[p*XW +: XW] ^ 16'h5A5A);
      end
      eng_done_i[p] = !rst_i &&
        ((due[p] == cyc && !miss[p]) ||
         (early[p] && due[p] - 5 == cyc));
      eng_x_i[p*XW +: XW] = eng_done_i[p] ? rx[p] : '0;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int rsp_seen;
  int start_seen;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk_i);
    #1;
    if (rsp_valid_o) rsp_seen++;
    if (|eng_start_o) start_seen++;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    rst_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  int a;
  int ng, nr, maxinf, bad, badr;
  int gid [4];
  int gcy [4];
  int qid [2];
  int qcy [2];
  logic [XW-1:0] qx [2];
  logic [TW-1:0] qt [2];

  initial begin
    for (int p = 0; p < N; p++) begin
      early[p] = 1'b0;
      miss[p]  = 1'b0;
    end
    use_fix = 1'b0;
    fixres  = '0;
    req_x_i = '0;
    req_tag_i = '0;
    rsp_ready_i = 1'b1;
    req_valid_i = 3'b111;
    rst_i = 1'b1;
    repeat (3) tick();
    chk("rst_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_start", eng_start_o, 0);
    chk("rst_engx", eng_x_o, 0);
    chk("rst_inflight", inflight_o, 0);
    chk("rst_err", err_o, 0);
    req_valid_i = '0;
    rst_i = 1'b0;

    // single job
    use_fix = 1'b1;
    fixres  = 16'h0ABC;
    wait_to(10);
    req_x_i[15:0]  = 16'h0005;
    req_tag_i[7:0] = 8'h11;
    req_valid_i    = 3'b001;
    #1;
    chk("t1_ready", req_ready_o, 3'b001);
    tick();
    req_valid_i = '0;
    chk("t1_start", eng_start_o, 2'b01);
    chk("t1_engx", eng_x_o, 32'h0000_0005);
    chk("t1_inflight", inflight_o, 1);
    tick();
    chk("t1_start_once", eng_start_o, 0);
    wait_to(269);
    chk("t1_no_early_rsp", rsp_valid_o, 0);
    tick();
    chk("t1_rsp_cyc", cyc, 270);
    chk("t1_rsp_valid", rsp_valid_o, 1);
    chk("t1_rsp_x", rsp_x_o, 16'h0ABC);
    chk("t1_rsp_id", rsp_id_o, 0);
    chk("t1_rsp_tag", rsp_tag_o, 8'h11);
    tick();
    chk("t1_drained", rsp_valid_o, 0);
    chk("t1_idle", inflight_o, 0);
    use_fix = 1'b0;

    // fairness with all requesters always valid
    do_reset();
    req_x_i     = {16'h0102, 16'h0101, 16'h0100};
    req_tag_i   = {8'h22, 8'h21, 8'h20};
    req_valid_i = 3'b111;
    ng = 0;
    nr = 0;
    maxinf = 0;
    for (int k = 0; k < 700 && ng < 4; k++) begin
      #1;
      if (int'(inflight_o) > maxinf) maxinf = int'(inflight_o);
      if (req_ready_o != 0) begin
        gid[ng] = oh_idx(req_ready_o);
        gcy[ng] = cyc;
        ng++;
      end
      if (rsp_valid_o && rsp_ready_i && nr < 2) begin
        qid[nr] = int'(rsp_id_o);
        qx[nr]  = rsp_x_o;
        qt[nr]  = rsp_tag_o;
        qcy[nr] = cyc;
        nr++;
      end
      if (ng < 4) tick();
    end
    req_valid_i = '0;
    chk("t2_grants", ng, 4);
    chk("t2_rsps", nr, 2);
    if (ng == 4 && nr == 2) begin
      chk("t2_g0", gid[0], 0);
      chk("t2_g1", gid[1], 1);
      chk("t2_g2", gid[2], 2);
      chk("t2_g3", gid[3], 0);
      chk("t2_g1_cyc", gcy[1] - gcy[0], 1);
      chk("t2_g2_stall", gcy[2] - gcy[0], L + 3);
      chk("t2_g3_cyc", gcy[3] - gcy[0], L + 4);
      chk("t2_r0_cyc", qcy[0] - gcy[0], L + 2);
      chk("t2_r0_id", qid[0], 0);
      chk("t2_r0_x", qx[0], 16'h5B5A);
      chk("t2_r0_tag", qt[0], 8'h20);
      chk("t2_r1_cyc", qcy[1] - gcy[0], L + 3);
      chk("t2_r1_id", qid[1], 1);
      chk("t2_r1_x", qx[1], 16'h5B5B);
    end
    chk("t2_maxinf", maxinf, 2);

    // backpressure with both lanes holding results
    do_reset();
    rsp_ready_i = 1'b0;
    req_x_i     = {16'h0000, 16'h0040, 16'h0030};
    req_tag_i   = {8'h00, 8'h41, 8'h31};
    req_valid_i = 3'b011;
    #1;
    chk("t3_ready0", req_ready_o, 3'b001);
    a = cyc;
    tick();
    chk("t3_ready1", req_ready_o, 3'b010);
    tick();
    req_valid_i = '0;
    wait_to(a + 2 + L);
    chk("t3_hold_valid", rsp_valid_o, 1);
    chk("t3_hold_x", rsp_x_o, 16'h5A6A);
    chk("t3_hold_tag", rsp_tag_o, 8'h31);
    req_valid_i = 3'b100;
    bad = 0;
    badr = 0;
    repeat (20) begin
      tick();
      if (!rsp_valid_o || rsp_x_o != 16'h5A6A ||
          rsp_id_o != 0 || rsp_tag_o != 8'h31) bad++;
      if (req_ready_o != 0) badr++;
    end
    chk("t3_stable", bad, 0);
    chk("t3_no_ready", badr, 0);
    chk("t3_inflight", inflight_o, 2);
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    #1;
    chk("t3_rel0_valid", rsp_valid_o, 1);
    chk("t3_rel0_id", rsp_id_o, 0);
    tick();
    chk("t3_rel1_valid", rsp_valid_o, 1);
    chk("t3_rel1_id", rsp_id_o, 1);
    chk("t3_rel1_x", rsp_x_o, 16'h5A1A);
    chk("t3_rel1_tag", rsp_tag_o, 8'h41);
    tick();
    chk("t3_empty", rsp_valid_o, 0);

    // early done on lane 0
    do_reset();
    early[0] = 1'b1;
    req_x_i[15:0]  = 16'h0077;
    req_tag_i[7:0] = 8'h55;
    req_valid_i    = 3'b001;
    a = cyc;
    tick();
    req_valid_i = '0;
    wait_to(a + L - 4);
    chk("t4_err_before", err_o, 0);
    tick();
    chk("t4_err_set", err_o, 1);
    chk("t4_still_run", inflight_o, 1);
    chk("t4_no_rsp", rsp_valid_o, 0);
    wait_to(a + 2 + L);
    chk("t4_rsp_valid", rsp_valid_o, 1);
    chk("t4_rsp_x", rsp_x_o, 16'h5A2D);
    chk("t4_rsp_tag", rsp_tag_o, 8'h55);
    tick();
    chk("t4_err_sticky", err_o, 1);
    early[0] = 1'b0;

    // missing done on lane 0
    do_reset();
    chk("t5_err_clr", err_o, 0);
    miss[0] = 1'b1;
    rsp_seen = 0;
    req_x_i[15:0]  = 16'h0099;
    req_valid_i    = 3'b001;
    a = cyc;
    tick();
    req_valid_i = '0;
    wait_to(a + 1 + L);
    chk("t5_err_before", err_o, 0);
    chk("t5_busy", inflight_o, 1);
    tick();
    chk("t5_err_set", err_o, 1);
    chk("t5_idle", inflight_o, 0);
    repeat (10) tick();
    chk("t5_no_rsp", rsp_seen, 0);
    miss[0] = 1'b0;

    // reset with two jobs in flight
    do_reset();
    req_x_i     = {16'h0000, 16'h0222, 16'h0111};
    req_valid_i = 3'b011;
    wait_to(10);
    tick();
    tick();
    req_valid_i = '0;
    chk("t6_inflight", inflight_o, 2);
    wait_to(100);
    req_valid_i = 3'b100;
    rst_i = 1'b1;
    #1;
    chk("t6_ready", req_ready_o, 0);
    chk("t6_rsp", rsp_valid_o, 0);
    chk("t6_start", eng_start_o, 0);
    chk("t6_inflight0", inflight_o, 0);
    repeat (3) tick();
    rst_i = 1'b0;
    req_valid_i = '0;
    rsp_seen = 0;
    start_seen = 0;
    repeat (400) tick();
    chk("t6_no_rsp", rsp_seen, 0);
    chk("t6_no_start", start_seen, 0);
    chk("t6_idle", inflight_o, 0);
    chk("t6_err", err_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/penta_root_sched.md
Name: penta_root_sched

Overview:
- Job scheduler in front of the penta root ring engine.
- Arbitrates 5th-root requests from NREQ requesters onto N engine start ports and tracks each in-flight job's tag and completion time.
- Buffers each result until the consumer accepts it, and returns results on a single valid/ready response channel.
- Sits between the host/VDF sequencing logic and the engine; no datapath arithmetic of its own.

Parameters:
- N, 1, number of engine ports (ring lanes); each port holds at most one job.
- NREQ, 2, number of requesters.
- XW, 1024, operand/result width in bits (poly width).
- TW, 8, requester tag width.
- LATENCY, 258, cycles from eng_start_o[p] high to the matching eng_done_i[p].

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- req_valid_i  in  NREQ  request valid per requester
- req_ready_o  out  NREQ  request accepted (one-hot or zero)
- req_x_i  in  NREQ*XW  operand per requester
- req_tag_i  in  NREQ*TW  tag per requester
- rsp_valid_o  out  1  result available
- rsp_ready_i  in  1  consumer accepts result
- rsp_x_o  out  XW  result value
- rsp_id_o  out  max(1,clog2(NREQ))  originating requester
- rsp_tag_o  out  TW  originating tag
- eng_start_o  out  N  engine start per port
- eng_x_o  out  N*XW  engine operand per port
- eng_done_i  in  N  engine done per port
- eng_x_i  in  N*XW  engine result per port
- inflight_o  out  clog2(N+1)  ports not IDLE
- err_o  out  1  sticky protocol error

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. clk_i is the clock and rst_i is the reset.
- Reset values:
  - all outputs 0;
  - all ports IDLE;
  - both round-robin pointers 0;
  - err_o 0.
- Per-port FSM states: IDLE, ISSUE, RUN, HOLD.
- Request arbitration:
  - Round-robin over req_valid_i, starting at req_ptr.
  - The grant goes only when at least one port is IDLE.
  - req_ready_o is asserted to the granted requester only; it may depend combinationally on req_valid_i.
  - Handshake = valid & ready. At most one accept per cycle.
  - On accept, req_ptr becomes grant+1 mod NREQ.
- Port choice: the lowest-index IDLE port is chosen. On accept it moves IDLE->ISSUE and latches operand, requester id and tag.
- ISSUE (exactly 1 cycle):
  - eng_start_o[p]=1 and eng_x_o[p]=latched operand.
  - The port counter loads LATENCY-1 and the port moves to RUN.
  - eng_x_o[p]=0 whenever eng_start_o[p]=0.
- RUN:
  - The counter decrements each cycle, so it reads 0 exactly LATENCY cycles after the ISSUE cycle.
  - eng_done_i[p] with counter==0: capture eng_x_i[p] into the result register and move to HOLD.
  - Counter==0 without done: set err_o, discard the job, move to IDLE.
- Spurious done: eng_done_i[p] while the port is IDLE, ISSUE, HOLD, or RUN with counter!=0 sets err_o and is otherwise ignored.
- err_o stays set until reset.
- Response arbitration:
  - Round-robin over HOLD ports, starting at rsp_ptr.
  - rsp_valid_o = any port in HOLD; rsp_x_o, rsp_id_o and rsp_tag_o come from the selected port.
  - While rsp_valid_o=1 and rsp_ready_i=0, the selection is locked: outputs stay stable even if other ports enter HOLD.
  - On handshake the port goes HOLD->IDLE and rsp_ptr becomes port+1 mod N.
  - When rsp_valid_o=0, rsp_x_o, rsp_id_o and rsp_tag_o are 0.
- Latency:
  - Accept at cycle t gives eng_start_o at t+1, eng_done_i at t+1+LATENCY, and rsp_valid_o at t+2+LATENCY.
  - A freed port can be re-granted in the cycle after its response handshake.
- Simultaneous events:
  - An accept and a response handshake in the same cycle are independent.
  - A port leaving HOLD that cycle is not eligible for the accept in that same cycle.
- Occupancy: inflight_o counts non-IDLE ports, registered. When all ports are busy, req_ready_o is all 0.
- Mid-operation reset: all in-flight jobs are dropped and nothing is emitted. The engine is reset by the same domain.

Test Plan:
- Single job, N=2, NREQ=3, LATENCY=258:
  - Stimulus: req0 x=5, tag=0x11 accepted at cycle 10; engine model returns 0xABC at cycle 269.
  - Required: eng_start_o=01 at cycle 11; rsp_valid_o at cycle 270 with x=0xABC, id=0, tag=0x11.
- Fairness:
  - Stimulus: all 3 requesters continuously valid, N=2, rsp_ready_i=1.
  - Required: grant order 0,1,2,0,…; third request stalls until a port frees.
  - Required: never more than 2 in flight; inflight_o reaches 2.
- Backpressure:
  - Stimulus: both ports reach HOLD; rsp_ready_i=0 for 20 cycles.
  - Required: rsp outputs stable on port 0; req_ready_o=0.
  - Required after release: port 0 then port 1 drained on consecutive cycles.
- Early done:
  - Stimulus: engine model asserts eng_done_i[0] at counter==5.
  - Required: err_o=1 and stays 1; the port stays in RUN; a later correct done still completes the job.
- Missing done:
  - Stimulus: no eng_done_i for a job.
  - Required: err_o=1 at the expected cycle; the port returns to IDLE; no response is emitted.
- Reset mid-flight:
  - Stimulus: rst_i pulsed at cycle 100 with 2 jobs in flight.
  - Required: all outputs 0 immediately; inflight_o=0; no responses are emitted after reset.
